// File: rtl/vga_cfg_sequencer.sv
// Two-requester arbiter that serializes cmd/data config writes onto the io_uio/io_strobe/io_din
// byte bus, optionally deferring cmd==1 (output-mode) writes to vblank.
module vga_cfg_sequencer #(
  parameter int STROBE_W = 2,
  parameter int GAP_W    = 2,
  parameter bit HOLD_VBL = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       vblank,
  input  logic       req_a_valid,
  input  logic [7:0] req_a_cmd,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [7:0] req_b_cmd,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic       io_uio,
  output logic       io_strobe,
  output logic [7:0] io_din,
  output logic       busy,
  output logic [7:0] cfg_shadow
);

  localparam int MAXW = (STROBE_W > GAP_W) ? STROBE_W : GAP_W;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] S_LD = CW'(STROBE_W - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_W - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_VBL, CMD_SU, CMD_HI, DAT_SU, DAT_HI, TAIL, OFF
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d, data_q, data_d, shadow_q, shadow_d, din_q, din_d;
  logic          last_b_q, last_b_d;
  logic          uio_q, uio_d, stb_q, stb_d, busy_q, busy_d;
  logic          grant_a, grant_b, done;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      shadow_q <= '0;
      last_b_q <= 1'b1;
      uio_q    <= 1'b0;
      stb_q    <= 1'b0;
      din_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      last_b_q <= last_b_d;
      uio_q    <= uio_d;
      stb_q    <= stb_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    last_b_d = last_b_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    done     = (cnt_q == '0);
    case (state_q)
      IDLE: begin
        // Round-robin: on a tie the requester not granted last time wins.
        grant_a = req_a_valid & (~req_b_valid | last_b_q);
        grant_b = req_b_valid & ~grant_a;
        if (grant_a | grant_b) begin
          cmd_d    = grant_a ? req_a_cmd  : req_b_cmd;
          data_d   = grant_a ? req_a_data : req_b_data;
          last_b_d = grant_b;
          state_d  = (HOLD_VBL && cmd_d == 8'h01) ? WAIT_VBL : CMD_SU;
        end
      end
      WAIT_VBL: if (vblank) state_d = CMD_SU;
      CMD_SU:   if (done) state_d = CMD_HI;
      CMD_HI:   if (done) state_d = DAT_SU;
      DAT_SU:   if (done) state_d = DAT_HI;
      DAT_HI: begin
        if (cnt_q == S_LD && cmd_q == 8'h01) shadow_d = data_q;
        if (done) state_d = TAIL;
      end
      TAIL:     if (done) state_d = OFF;
      OFF:      if (done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_d != state_q)
      cnt_d = (state_d == CMD_HI || state_d == DAT_HI) ? S_LD : G_LD;
    else if (!done)
      cnt_d = cnt_q - CW'(1);

    // Bus outputs are decoded from the next state so the flops track the FSM with no lag.
    uio_d  = state_d inside {CMD_SU, CMD_HI, DAT_SU, DAT_HI, TAIL};
    stb_d  = state_d inside {CMD_HI, DAT_HI};
    busy_d = (state_d != IDLE);
    case (state_d)
      CMD_SU, CMD_HI:       din_d = cmd_d;
      DAT_SU, DAT_HI, TAIL: din_d = data_d;
      default:              din_d = '0;
    endcase
  end

  assign req_a_ready = grant_a & ~reset;
  assign req_b_ready = grant_b & ~reset;
  assign io_uio      = uio_q;
  assign io_strobe   = stb_q;
  assign io_din      = din_q;
  assign busy        = busy_q;
  assign cfg_shadow  = shadow_q;

endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// Random/directed bench for vga_cfg_sequencer: a timing-window reference model plus a
// behavioural bus receiver scoreboard.
module tb_vga_cfg_sequencer;

  localparam int G     = 2;
  localparam int S     = 2;
  localparam int TXN   = 4*G + 2*S;
  localparam int UIO_N = 3*G + 2*S;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       vblank  = 1'b1;
  logic       req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic [7:0] req_a_cmd = '0, req_a_data = '0, req_b_cmd = '0, req_b_data = '0;
  logic       req_a_ready, req_b_ready;
  logic       io_uio, io_strobe, busy;
  logic [7:0] io_din, cfg_shadow;

  int n_chk = 0;
  int n_err = 0;

  vga_cfg_sequencer #(.STROBE_W(S), .GAP_W(G), .HOLD_VBL(1'b1)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vblank      (vblank),
    .req_a_valid (req_a_valid),
    .req_a_cmd   (req_a_cmd),
    .req_a_data  (req_a_data),
    .req_a_ready (req_a_ready),
    .req_b_valid (req_b_valid),
    .req_b_cmd   (req_b_cmd),
    .req_b_data  (req_b_data),
    .req_b_ready (req_b_ready),
    .io_uio      (io_uio),
    .io_strobe   (io_strobe),
    .io_din      (io_din),
    .busy        (busy),
    .cfg_shadow  (cfg_shadow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Call at posedge+1; holds valid until a ready is seen, drops it after that edge.
  task automatic drive(input bit sel_b, input logic [7:0] c, input logic [7:0] d);
    int n = 0;
    if (sel_b) begin req_b_cmd = c; req_b_data = d; req_b_valid = 1'b1; end
    else       begin req_a_cmd = c; req_a_data = d; req_a_valid = 1'b1; end
    @(negedge clk_sys);
    while (!(sel_b ? req_b_ready : req_a_ready) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    chk(sel_b ? "b_accept" : "a_accept", 32'(sel_b ? req_b_ready : req_a_ready), 32'd1);
    @(posedge clk_sys);
    #1;
    if (sel_b) req_b_valid = 1'b0; else req_a_valid = 1'b0;
  endtask

  // Reference model: transaction windows from accept/vblank times; receiver decodes the bus.
  int         cyc = 0, free_at = 0, acc = -1000, start = -1000, o;
  bit         waiting = 0, last_b = 1, pend = 0, ea, eb, prev_stb = 0, has_cmd = 0;
  logic [7:0] tc = '0, td = '0, sh = '0, rcmd = '0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  initial begin
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (reset) begin
        free_at = cyc; acc = -1000; start = -1000; waiting = 0; last_b = 1;
        sh = '0; pend = 0; exp_q.delete(); has_cmd = 0; prev_stb = 0;
        continue;
      end
      if (waiting && vblank) begin
        waiting = 0; start = cyc + 1; free_at = start + TXN;
      end
      if (pend && cyc >= free_at) begin
        if (tc == 8'h01) sh = td;
        pend = 0;
      end
      ea = 0; eb = 0;
      if (cyc >= free_at) begin
        if (req_a_valid && (!req_b_valid || last_b)) ea = 1;
        else if (req_b_valid) eb = 1;
      end
      chk("ready_a", 32'(req_a_ready), 32'(ea));
      chk("ready_b", 32'(req_b_ready), 32'(eb));
      o = cyc - start;
      chk("uio", 32'(io_uio), 32'(o >= 0 && o < UIO_N));
      chk("strobe", 32'(io_strobe), 32'((o >= G && o < G+S) || (o >= 2*G+S && o < 2*G+2*S)));
      chk("busy", 32'(busy), 32'(cyc > acc && cyc < free_at));
      if (o >= 0 && o < G+S)              chk("din_cmd", 32'(io_din), 32'(tc));
      else if (o >= G+S && o < 2*G+2*S)   chk("din_data", 32'(io_din), 32'(td));
      else if (o >= UIO_N && o < TXN)     chk("din_off", 32'(io_din), 32'd0);
      if (cyc >= free_at) chk("shadow", 32'(cfg_shadow), 32'(sh));
      if (!io_uio) has_cmd = 0;
      if (io_strobe && !prev_stb) begin
        if (!has_cmd) begin
          rcmd = io_din; has_cmd = 1;
        end else begin
          has_cmd = 0;
          if (exp_q.size() == 0) chk("rx_extra", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rx_pair", 32'({rcmd, io_din}), 32'(e));
          end
        end
      end
      prev_stb = io_strobe;
      if (ea || eb) begin
        tc = ea ? req_a_cmd  : req_b_cmd;
        td = ea ? req_a_data : req_b_data;
        last_b = eb; acc = cyc; pend = 1;
        exp_q.push_back({tc, td});
        if (tc == 8'h01) begin
          waiting = 1; free_at = 1 << 30; start = -1000;
        end else begin
          start = cyc + 1; free_at = start + TXN;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  bit rand_done = 0;

  initial begin
    // Reset values, with a request already pending.
    req_a_valid = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_uio", 32'(io_uio), 32'd0);
    chk("rst_stb", 32'(io_strobe), 32'd0);
    chk("rst_din", 32'(io_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shadow", 32'(cfg_shadow), 32'd0);
    chk("rst_ready", 32'(req_a_ready), 32'd0);
    req_a_valid = 1'b0;
    reset = 1'b0;

    // Tie after reset: A first, then B; tie again goes back to A.
    fork
      drive(1'b0, 8'h01, 8'h24);
      drive(1'b1, 8'h03, 8'h5A);
    join
    fork
      drive(1'b0, 8'h07, 8'h11);
      drive(1'b1, 8'h09, 8'h22);
    join
    repeat (20) @(posedge clk_sys);
    #1;
    chk("t1_shadow", 32'(cfg_shadow), 32'h24);

    // cmd==1 held off by vblank for 50 cycles.
    vblank = 1'b0;
    drive(1'b0, 8'h01, 8'h08);
    repeat (50) @(posedge clk_sys);
    #1;
    vblank = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1;
    chk("t3_shadow", 32'(cfg_shadow), 32'h08);

    // cmd!=1 ignores vblank and leaves the shadow alone.
    vblank = 1'b0;
    drive(1'b1, 8'h02, 8'hFF);
    repeat (16) @(posedge clk_sys);
    #1;
    chk("t4_shadow", 32'(cfg_shadow), 32'h08);

    // Reset during DAT_HI with B pending; B must be accepted after release.
    fork
      drive(1'b1, 8'h04, 8'h33);
    join_none
    drive(1'b0, 8'h05, 8'h44);
    repeat (6) @(posedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_uio", 32'(io_uio), 32'd0);
    chk("t5_stb", 32'(io_strobe), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_shadow", 32'(cfg_shadow), 32'd0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    wait fork;
    repeat (16) @(posedge clk_sys);
    #1;

    // Random traffic from both requesters with random vblank.
    fork
      begin
        fork
          for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk_sys);
            @(posedge clk_sys);
            #1;
            drive(1'b0, ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom), 8'($urandom));
          end
          for (int j = 0; j < 15; j++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk_sys);
            @(posedge clk_sys);
            #1;
            drive(1'b1, ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom), 8'($urandom));
          end
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk_sys);
          #1;
          vblank = ($urandom_range(0, 7) == 0);
        end
        vblank = 1'b1;
      end
    join
    repeat (30) @(posedge clk_sys);
    #1;
    chk("rx_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
